// File: rtl/uart_pia_ctrl.sv
// Apple 1 PIA-style register window (D010-D013) in front of the USB UART:
// RX FIFO with overrun and CTS, TX holding register and TX sequencer.
// Optional feature: define PIA_UART_CRLF_EN to follow every transmitted CR with an LF.
module uart_pia_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CTS_LEVEL = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_busy,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       cts
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TO_W  = 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CTS_CNT  = CNT_W'(CTS_LEVEL);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(3);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_HI,
`ifdef PIA_UART_CRLF_EN
    TX_WAIT_LO,
    TX_LF
`else
    TX_WAIT_LO
`endif
  } tx_state_t;

  logic [6:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overrun;
  logic [6:0]       hold;
  logic             hold_full;
  tx_state_t        state;
  logic [TO_W-1:0]  to_cnt;
`ifdef PIA_UART_CRLF_EN
  logic             last_cr;
`endif

  logic       rd_acc;
  logic       wr_acc;
  logic       empty;
  logic       full;
  logic       pop;
  logic       push;
  logic       ovr_evt;
  logic       tx_pending;
  logic [7:0] rd_mux;
  logic       unused_bits;

  assign rd_acc      = stb & cs & ~we;
  assign wr_acc      = stb & cs & we;
  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign pop         = rd_acc & (addr == 2'd0) & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push        = rx_valid & (~full | pop);
  assign ovr_evt     = rx_valid & full & ~pop;
  assign tx_pending  = hold_full | (state != TX_IDLE);
  assign unused_bits = ^{rx_data[7], wdata[7]};

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      2'd0:    rd_mux = empty ? 8'h00 : {1'b1, mem[rd_ptr]};
      2'd1:    rd_mux = {~empty, 7'b0};
      2'd2:    rd_mux = {tx_pending, 7'b0};
      default: rd_mux = {overrun, 3'b0, count};
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data[6:0];
  end

  // FIFO bookkeeping, overrun flag, read data and CTS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      rdata   <= 8'h00;
      cts     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovr_evt)
        overrun <= 1'b1;
      else if (rd_acc && (addr == 2'd3))
        overrun <= 1'b0;
      if (rd_acc) rdata <= rd_mux;
      cts <= rx_busy | (count >= CTS_CNT);
    end
  end

  // TX sequencer; a bus write lands after the FSM so it wins over the clear in TX_START
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TX_IDLE;
      hold      <= 7'h00;
      hold_full <= 1'b0;
      to_cnt    <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
`ifdef PIA_UART_CRLF_EN
      last_cr   <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (hold_full && !tx_busy) state <= TX_START;
        end
        TX_START: begin
          tx_start  <= 1'b1;
          tx_data   <= {1'b0, hold};
          hold_full <= 1'b0;
          to_cnt    <= '0;
`ifdef PIA_UART_CRLF_EN
          last_cr   <= (hold == 7'h0D);
`endif
          state     <= TX_WAIT_HI;
        end
        TX_WAIT_HI: begin
          // The UART may never report busy; give up after four cycles.
          if (tx_busy || (to_cnt == TO_LAST))
            state <= TX_WAIT_LO;
          else
            to_cnt <= to_cnt + TO_W'(1);
        end
        TX_WAIT_LO: begin
          if (!tx_busy) begin
`ifdef PIA_UART_CRLF_EN
            state <= last_cr ? TX_LF : TX_IDLE;
`else
            state <= TX_IDLE;
`endif
          end
        end
`ifdef PIA_UART_CRLF_EN
        TX_LF: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= 8'h0A;
            last_cr  <= 1'b0;
            to_cnt   <= '0;
            state    <= TX_WAIT_HI;
          end
        end
`endif
        default: state <= TX_IDLE;
      endcase
      if (wr_acc && (addr == 2'd2)) begin
        hold      <= wdata[6:0];
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_pia_ctrl.sv
// Directed self-checking bench for uart_pia_ctrl (DEPTH=8, CTS_LEVEL=6).
module tb_uart_pia_ctrl;

  logic       clk;
  logic       rst;
  logic       stb;
  logic       cs;
  logic [1:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_busy;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       cts;

  int n_assert = 0;
  int n_fail   = 0;
  int n_starts = 0;
  logic [7:0] last_tx = 8'h00;

  uart_pia_ctrl #(.DEPTH(8), .CTS_LEVEL(6)) dut (
    .clk(clk), .rst(rst), .stb(stb), .cs(cs), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_busy(rx_busy), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .cts(cts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && tx_start) begin
      n_starts = n_starts + 1;
      last_tx  = tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    stb = 1'b1; cs = 1'b1; we = 1'b0; addr = a;
    tick();
    stb = 1'b0; cs = 1'b0;
    d = rdata;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] v);
    stb = 1'b1; cs = 1'b1; we = 1'b1; addr = a; wdata = v;
    tick();
    stb = 1'b0; cs = 1'b0; we = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int s0;
    int n_idle;

    rst = 1'b1; stb = 1'b0; cs = 1'b0; addr = 2'd0; we = 1'b0; wdata = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; rx_busy = 1'b0; tx_busy = 1'b0;
    tick();
    tick();
    check("reset_rdata", rdata, 8'h00);
    check("reset_cts", {7'b0, cts}, 8'h00);
    check("reset_tx_start", {7'b0, tx_start}, 8'h00);
    check("reset_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    tick();

    bus_rd(2'd1, d); check("empty_ctrl", d, 8'h00);
    bus_rd(2'd0, d); check("empty_data", d, 8'h00);
    bus_rd(2'd3, d); check("empty_status", d, 8'h00);

    push(8'hC1);
    push(8'h42);
    bus_rd(2'd1, d); check("ctrl_nonempty", d, 8'h80);
    bus_rd(2'd0, d); check("rd_first", d, 8'hC1);
    bus_rd(2'd0, d); check("rd_second", d, 8'hC2);
    bus_rd(2'd1, d); check("ctrl_drained", d, 8'h00);

    // Nine pushes into an 8-deep FIFO; cts follows the count one cycle late.
    for (int i = 0; i < 9; i++) begin
      push(8'(8'h10 + i));
      check($sformatf("cts_after_push%0d", i), {7'b0, cts}, (i >= 6) ? 8'h01 : 8'h00);
    end
    bus_rd(2'd3, d); check("status_overrun", d, 8'h88);
    bus_rd(2'd3, d); check("status_cleared", d, 8'h08);

    // Full FIFO: push coincident with pop is accepted without overrun.
    rx_valid = 1'b1; rx_data = 8'h55;
    stb = 1'b1; cs = 1'b1; we = 1'b0; addr = 2'd0;
    tick();
    rx_valid = 1'b0; stb = 1'b0; cs = 1'b0;
    check("coincident_pop", rdata, 8'h90);
    bus_rd(2'd3, d); check("coincident_status", d, 8'h08);

    // Overrun in the same cycle as a status read stays set.
    rx_valid = 1'b1; rx_data = 8'h66;
    stb = 1'b1; cs = 1'b1; we = 1'b0; addr = 2'd3;
    tick();
    rx_valid = 1'b0; stb = 1'b0; cs = 1'b0;
    check("ovr_prio_read", rdata, 8'h08);
    bus_rd(2'd3, d); check("ovr_prio_kept", d, 8'h88);
    bus_rd(2'd3, d); check("ovr_prio_clear", d, 8'h08);

    for (int i = 1; i < 8; i++) begin
      bus_rd(2'd0, d);
      check($sformatf("drain%0d", i), d, 8'(8'h90 + i));
    end
    bus_rd(2'd0, d); check("drain_last", d, 8'hD5);
    bus_rd(2'd0, d); check("drain_empty", d, 8'h00);
    bus_rd(2'd1, d); check("drain_ctrl", d, 8'h00);
    check("cts_drained", {7'b0, cts}, 8'h00);

    rx_busy = 1'b1; tick();
    check("cts_rx_busy", {7'b0, cts}, 8'h01);
    rx_busy = 1'b0; tick();
    check("cts_rx_idle", {7'b0, cts}, 8'h00);

    bus_wr(2'd0, 8'hFF);
    bus_wr(2'd3, 8'hFF);
    bus_rd(2'd3, d); check("ignored_writes", d, 8'h00);

    // TX with a well-behaved UART.
    s0 = n_starts;
    bus_wr(2'd2, 8'h41);
    check("tx_start_e0", {7'b0, tx_start}, 8'h00);
    tick();
    check("tx_start_e1", {7'b0, tx_start}, 8'h00);
    tick();
    check("tx_start_e2", {7'b0, tx_start}, 8'h01);
    check("tx_data_41", tx_data, 8'h41);
    tx_busy = 1'b1;
    tick();
    check("tx_start_pulse_end", {7'b0, tx_start}, 8'h00);
    bus_rd(2'd2, d); check("tx_pending_busy", d, 8'h80);
    tick(); tick(); tick();
    bus_rd(2'd2, d); check("tx_pending_still", d, 8'h80);
    tx_busy = 1'b0;
    tick();
    bus_rd(2'd2, d); check("tx_pending_done", d, 8'h00);
    check("tx_single_start", 8'(n_starts - s0), 8'h01);

    // TX with a UART that never raises busy: the wait times out.
    bus_wr(2'd2, 8'h42);
    tick();
    tick();
    check("to_tx_start", {7'b0, tx_start}, 8'h01);
    check("to_tx_data", tx_data, 8'h42);
    n_idle = 0;
    for (int n = 1; n <= 8; n++) begin
      bus_rd(2'd2, d);
      if (d == 8'h00 && n_idle == 0) n_idle = n;
    end
    check("to_idle_read", 8'(n_idle), 8'h06);

    // CR handling.
    s0 = n_starts;
    bus_wr(2'd2, 8'h8D);
    for (int i = 0; i < 8 && n_starts == s0; i++) tick();
    check("cr_started", 8'(n_starts - s0), 8'h01);
    check("cr_data", last_tx, 8'h0D);
    tx_busy = 1'b1;
    tick(); tick(); tick();
    tx_busy = 1'b0;
    s0 = n_starts;
    for (int i = 0; i < 8; i++) tick();
`ifdef PIA_UART_CRLF_EN
    check("lf_started", 8'(n_starts - s0), 8'h01);
    check("lf_data", last_tx, 8'h0A);
`else
    check("no_lf", 8'(n_starts - s0), 8'h00);
    check("cr_last", last_tx, 8'h0D);
`endif
    for (int i = 0; i < 10; i++) tick();
    bus_rd(2'd2, d); check("cr_final_idle", d, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
